seq_mult_core: RTL and testbench

- Unsigned shift-add sequential multiplier; the consumer/reader side of the operand registers.
- Accepts a multiplicand/multiplier pair through a valid/ready handshake and iterates one partial product per clock.
- Presents the 2N-bit product through a valid/ready handshake to the result stage of the multiplication pipeline.

---
 rtl/mult_pkg.sv | 17 +
 rtl/add_nbits.sv | 13 +
 rtl/seq_mult_core.sv | 92 +++++++++
 tb/tb_seq_mult_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  localparam int MULT_N = 16;

  // Iteration counter must hold the value N after the last CALC cycle.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/add_nbits.sv
// N-bit unsigned adder with carry-out for the partial-product add.
module add_nbits #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_mult_core.sv
// Unsigned shift-add multiplier: one partial product per clock, N cycles per
// product, valid/ready handshakes on both the operand and the result side.
module seq_mult_core
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CW = cnt_width(N);

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   m_reg;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic           carry;
  logic [2*N-1:0] acc_shift;
  logic           last;
  logic           load;

  // The adder carry-out is the accumulator's top bit; the same-cycle shift
  // absorbs it, so only 2N bits need to be stored between iterations.
  assign addend    = acc[0] ? m_reg : '0;
  assign acc_shift = {carry, sum, acc[N-1:1]};
  assign last      = (cnt == CW'(N - 1));
  assign load      = in_valid & in_ready;

  add_nbits #(.N(N)) u_add (
    .a    (acc[2*N-1:N]),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      m_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        m_reg <= a_in;
        acc   <= {{N{1'b0}}, b_in};
        cnt   <= '0;
      end else if (state == CALC) begin
        acc <= acc_shift;
        cnt <= cnt + CW'(1);
        if (last) product <= acc_shift;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_core.sv
// Directed bench for seq_mult_core with a cycle-level reference model.
module tb_seq_mult_core;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a_in = '0;
  logic [N-1:0]   b_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-1:0] product;
  logic           busy;

  int tests_run = 0;
  int tests_failed = 0;

  seq_mult_core #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: a product a*b appears N cycles after acceptance, held until taken.
  int             m_left = 0;
  logic           m_hold = 1'b0;
  logic [2*N-1:0] m_pend = '0;
  logic [2*N-1:0] m_prod = '0;
  logic           m_in_ready;

  assign m_in_ready = rst && ((m_left == 0 && !m_hold) || (m_hold && out_ready));

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0;
      m_hold <= 1'b0;
      m_pend <= '0;
      m_prod <= '0;
    end else begin
      if (m_hold && out_ready) m_hold <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hold <= 1'b1;
          m_prod <= m_pend;
        end
      end
      if (in_valid && m_in_ready) begin
        m_pend <= (2*N)'(a_in) * (2*N)'(b_in);
        m_left <= N;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [2*N-1:0] actual,
                             input logic [2*N-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model.out_valid", (2*N)'(out_valid), (2*N)'(m_hold));
    checkOutput("model.busy", (2*N)'(busy), (2*N)'(m_left > 0));
    checkOutput("model.in_ready", (2*N)'(in_ready), (2*N)'(m_in_ready));
    checkOutput("model.product", product, m_prod);
  end

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!out_valid && cycles < 100) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  int cyc;
  int bcyc;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.out_valid", (2*N)'(out_valid), '0);
    checkOutput("reset.busy", (2*N)'(busy), '0);
    checkOutput("reset.product", product, '0);
    checkOutput("reset.in_ready", (2*N)'(in_ready), '0);
    rst = 1'b1;
    #1;
    checkOutput("release.in_ready", (2*N)'(in_ready), 1);

    // 3 x 5 with a fixed 16-cycle latency
    applyStimulus(16'd3, 16'd5);
    waitResult(cyc, bcyc);
    checkOutput("t1.latency", (2*N)'(cyc), 16);
    checkOutput("t1.busy_cycles", (2*N)'(bcyc), 16);
    checkOutput("t1.product", product, 32'h0000000F);

    // Maximum operands, then a power-of-two pair back-to-back
    applyStimulus(16'hFFFF, 16'hFFFF);
    waitResult(cyc, bcyc);
    checkOutput("t2.product_max", product, 32'hFFFE0001);
    applyStimulus(16'h8000, 16'h0002);
    waitResult(cyc, bcyc);
    checkOutput("t2.latency", (2*N)'(cyc), 16);
    checkOutput("t2.product_pow2", product, 32'h00010000);

    // Backpressure holds the result
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(16'h00FF, 16'h0100);
    waitResult(cyc, bcyc);
    checkOutput("t3.product", product, 32'h0000FF00);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t3.hold_product", product, 32'h0000FF00);
      checkOutput("t3.hold_valid", (2*N)'(out_valid), 1);
      checkOutput("t3.hold_in_ready", (2*N)'(in_ready), '0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t3.valid_drop", (2*N)'(out_valid), '0);

    // Back-to-back load during the HOLD handshake
    out_ready = 1'b0;
    applyStimulus(16'd5, 16'd6);
    waitResult(cyc, bcyc);
    checkOutput("t4.first_product", product, 32'h0000001E);
    out_ready = 1'b1;
    applyStimulus(16'h1234, 16'h0010);
    checkOutput("t4.busy_next", (2*N)'(busy), 1);
    checkOutput("t4.valid_next", (2*N)'(out_valid), '0);
    waitResult(cyc, bcyc);
    checkOutput("t4.latency", (2*N)'(cyc), 16);
    checkOutput("t4.product", product, 32'h00012340);

    // Asynchronous reset in the seventh CALC cycle
    @(posedge clk);
    #1;
    applyStimulus(16'h00FF, 16'h0101);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("t5.abort_valid", (2*N)'(out_valid), '0);
    checkOutput("t5.abort_busy", (2*N)'(busy), '0);
    checkOutput("t5.abort_product", product, '0);
    checkOutput("t5.abort_in_ready", (2*N)'(in_ready), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t5.release_in_ready", (2*N)'(in_ready), 1);
    applyStimulus(16'd7, 16'd9);
    waitResult(cyc, bcyc);
    checkOutput("t5.latency", (2*N)'(cyc), 16);
    checkOutput("t5.product", product, 32'h0000003F);

    // Operand pulses while busy must be ignored
    @(posedge clk);
    #1;
    applyStimulus(16'd2, 16'd2);
    repeat (2) @(posedge clk);
    #1;
    a_in = 16'hAAAA;
    b_in = 16'h5555;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitResult(cyc, bcyc);
    checkOutput("t6.product", product, 32'h00000004);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      checkOutput("t6.no_second_result", (2*N)'(out_valid), '0);
      @(posedge clk);
      #1;
    end
    checkOutput("t6.product_kept", product, 32'h00000004);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
